// File: rtl/fractal_pkg.sv
// Shared types for the fractal generator control path.
//   fixed_t     : signed Q4.28 value used for c, pitch and origin
//   dim_t       : resolution in pixels / lines
//   frac_cfg_t  : one frame configuration as offered by the register block
//   seq_state_t : frame sequencer state
package fractal_pkg;

    localparam int FRAC_BITS = 28;

    typedef logic signed [31:0] fixed_t;
    typedef logic [15:0]        dim_t;

    typedef struct packed {
        dim_t   width;
        dim_t   height;
        fixed_t cr0;
        fixed_t ci0;
        fixed_t dcr;
        fixed_t dci;
        fixed_t dx;
        fixed_t dy;
        fixed_t x0;
        fixed_t y0;
    } frac_cfg_t;

    typedef enum logic {
        GEN_RST = 1'b0,
        RUN     = 1'b1
    } seq_state_t;

endpackage

// File: rtl/frame_line_counter.sv
// Counts generator line_end strobes to find the last line of each frame.
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : low holds the counter at line 0 and ignores strobes
//   frame_start  : forces the count back to the first line
//   line_end     : end of one line
//   height       : lines per frame
//   frame_done   : one-cycle pulse on the line_end that closes a frame
module frame_line_counter
    import fractal_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic frame_start,
    input  logic line_end,
    input  dim_t height,
    output logic frame_done
);

    dim_t line_cnt;
    dim_t line_base;

    // frame_start takes effect before a coincident line_end is counted
    always_comb begin
        line_base  = frame_start ? '0 : line_cnt;
        frame_done = enable && line_end && (line_base == dim_t'(height - 16'd1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cnt <= '0;
        end else if (!enable) begin
            line_cnt <= '0;
        end else if (line_end) begin
            line_cnt <= frame_done ? '0 : dim_t'(line_base + 16'd1);
        end else if (frame_start) begin
            line_cnt <= '0;
        end
    end

endmodule

// File: rtl/fractal_frame_sequencer.sv
// Frame-level controller for fractal_generator: owns its configuration and
// reset, accepts new configurations via valid/ready, sweeps the Julia
// constant c back and forth one step per frame, and re-resets the generator
// whenever the resolution changes.
//   cfg_*                 : configuration offered by the register block
//   cfg_valid/cfg_ready   : configuration handshake
//   pause                 : freeze the sweep (pending configs still apply)
//   frame_start, line_end : generator tuser/tlast, already tvalid-qualified
//   gen_resetn            : generator reset, active-low
//   width..y0             : registered generator configuration
//   frame_idx             : current sweep index k
//   busy                  : generator in reset or a configuration pending
module fractal_frame_sequencer
    import fractal_pkg::*;
#(
    parameter int RESET_CYCLES = 8,
    parameter int FRAME_W      = 16,
    parameter int DEF_WIDTH    = 1920,
    parameter int DEF_HEIGHT   = 1080
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [15:0]         cfg_width,
    input  logic [15:0]         cfg_height,
    input  logic signed [31:0]  cfg_cr0,
    input  logic signed [31:0]  cfg_ci0,
    input  logic signed [31:0]  cfg_dcr,
    input  logic signed [31:0]  cfg_dci,
    input  logic [FRAME_W-1:0]  cfg_frames,
    input  logic signed [31:0]  cfg_dx,
    input  logic signed [31:0]  cfg_dy,
    input  logic signed [31:0]  cfg_x0,
    input  logic signed [31:0]  cfg_y0,
    input  logic                pause,
    input  logic                frame_start,
    input  logic                line_end,
    output logic                gen_resetn,
    output logic [15:0]         width,
    output logic [15:0]         height,
    output logic signed [31:0]  cr,
    output logic signed [31:0]  ci,
    output logic signed [31:0]  dx,
    output logic signed [31:0]  dy,
    output logic signed [31:0]  x0,
    output logic signed [31:0]  y0,
    output logic [FRAME_W-1:0]  frame_idx,
    output logic                busy
);

    localparam int RC_W = $clog2(RESET_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    seq_state_t         state, state_n;
    logic [RC_W-1:0]    rst_cnt, rst_cnt_n;
    logic               pending, pending_n;
    logic               dir_up, dir_up_n;
    frac_cfg_t          shadow, shadow_n, cfg_in, load_src;
    logic [FRAME_W-1:0] shadow_frames, frames_n, k_n;
    logic               gen_resetn_n, cfg_ready_n, busy_n;
    dim_t               width_n, height_n;
    fixed_t             cr_n, ci_n, dx_n, dy_n, x0_n, y0_n;
    logic               frame_done, accept, load, go_up;

    assign cfg_in = '{width: cfg_width, height: cfg_height,
                      cr0: cfg_cr0, ci0: cfg_ci0, dcr: cfg_dcr, dci: cfg_dci,
                      dx: cfg_dx, dy: cfg_dy, x0: cfg_x0, y0: cfg_y0};

    frame_line_counter u_line_counter (
        .clk         (clk),
        .reset       (reset),
        .enable      (state == RUN),
        .frame_start (frame_start),
        .line_end    (line_end),
        .height      (height),
        .frame_done  (frame_done)
    );

    always_comb begin
        state_n      = state;
        rst_cnt_n    = rst_cnt;
        gen_resetn_n = gen_resetn;
        pending_n    = pending;
        dir_up_n     = dir_up;
        k_n          = frame_idx;
        cr_n         = cr;
        ci_n         = ci;
        width_n      = width;
        height_n     = height;
        dx_n         = dx;
        dy_n         = dy;
        x0_n         = x0;
        y0_n         = y0;
        shadow_n     = shadow;
        frames_n     = shadow_frames;
        load         = 1'b0;
        load_src     = shadow;
        accept       = cfg_valid && cfg_ready;
        // Reversal at either end of the sweep folds into the opposite step
        go_up        = dir_up ? (frame_idx < shadow_frames - FRAME_W'(1))
                              : (frame_idx == '0);

        case (state)
            GEN_RST: begin
                gen_resetn_n = 1'b0;
                if (rst_cnt == RC_LAST) begin
                    state_n      = RUN;
                    rst_cnt_n    = '0;
                    gen_resetn_n = 1'b1;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            RUN: begin
                if (frame_done && pending) begin
                    load      = 1'b1;
                    pending_n = 1'b0;
                end else if (frame_done && !pause && shadow_frames > FRAME_W'(1)) begin
                    dir_up_n = go_up;
                    if (go_up) begin
                        k_n  = frame_idx + 1'b1;
                        cr_n = cr + shadow.dcr;
                        ci_n = ci + shadow.dci;
                    end else begin
                        k_n  = frame_idx - 1'b1;
                        cr_n = cr - shadow.dcr;
                        ci_n = ci - shadow.dci;
                    end
                end
                // The step above already used the old shadow values
                if (accept) begin
                    shadow_n = cfg_in;
                    frames_n = cfg_frames;
                    if (cfg_width != width || cfg_height != height) begin
                        load         = 1'b1;
                        load_src     = cfg_in;
                        state_n      = GEN_RST;
                        rst_cnt_n    = '0;
                        gen_resetn_n = 1'b0;
                        pending_n    = 1'b0;
                    end else begin
                        pending_n = 1'b1;
                    end
                end
            end
            default: state_n = GEN_RST;
        endcase

        if (load) begin
            width_n  = load_src.width;
            height_n = load_src.height;
            dx_n     = load_src.dx;
            dy_n     = load_src.dy;
            x0_n     = load_src.x0;
            y0_n     = load_src.y0;
            cr_n     = load_src.cr0;
            ci_n     = load_src.ci0;
            k_n      = '0;
            dir_up_n = 1'b1;
        end

        cfg_ready_n = (state_n == RUN) && !pending_n;
        busy_n      = (state_n == GEN_RST) || pending_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= GEN_RST;
            rst_cnt       <= '0;
            gen_resetn    <= 1'b0;
            cfg_ready     <= 1'b0;
            busy          <= 1'b1;
            pending       <= 1'b0;
            dir_up        <= 1'b1;
            frame_idx     <= '0;
            shadow        <= '0;
            shadow_frames <= '0;
            width         <= dim_t'(DEF_WIDTH);
            height        <= dim_t'(DEF_HEIGHT);
            cr            <= '0;
            ci            <= '0;
            dx            <= '0;
            dy            <= '0;
            x0            <= '0;
            y0            <= '0;
        end else begin
            state         <= state_n;
            rst_cnt       <= rst_cnt_n;
            gen_resetn    <= gen_resetn_n;
            cfg_ready     <= cfg_ready_n;
            busy          <= busy_n;
            pending       <= pending_n;
            dir_up        <= dir_up_n;
            frame_idx     <= k_n;
            shadow        <= shadow_n;
            shadow_frames <= frames_n;
            width         <= width_n;
            height        <= height_n;
            cr            <= cr_n;
            ci            <= ci_n;
            dx            <= dx_n;
            dy            <= dy_n;
            x0            <= x0_n;
            y0            <= y0_n;
        end
    end

endmodule
